// File: rtl/spin_readout_if.sv
// Result channel of the spin readout: resolved spin vector plus per-spin
// mismatch counts, delivered with a valid/ready handshake.
interface spin_readout_if #(
    parameter int N     = 8,
    parameter int CNT_W = 9
);
    logic                 spins_valid;
    logic                 spins_ready;
    logic [N-1:0]         spins;
    logic [N*CNT_W-1:0]   counts;

    modport master (
        output spins_valid,
        output spins,
        output counts,
        input  spins_ready
    );

    modport slave (
        input  spins_valid,
        input  spins,
        input  counts,
        output spins_ready
    );
endinterface

// File: rtl/spin_readout.sv
// Oscillator spin readout: synchronizes each oscillator and the reference, counts
// phase mismatches over a fixed window and resolves one binary spin per oscillator.
module spin_readout #(
    parameter int N      = 8,
    parameter int WINDOW = 256,
    parameter int SYNC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      osc_in,
    input  logic              ref_in,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    spin_readout_if.master    res
);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int FL_W  = $clog2(SYNC + 1);

    localparam logic [CNT_W-1:0] HALF    = CNT_W'(WINDOW / 2);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WINDOW - 1);
    localparam logic [FL_W-1:0]  FL_LAST = FL_W'(SYNC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_MEAS  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [N-1:0]     osc_sync [SYNC];
    logic [SYNC-1:0]  ref_sync;
    logic [N-1:0]     mismatch;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];

    // Majority decision; an exact tie resolves to spin 0.
    function automatic logic resolve_spin(input logic [CNT_W-1:0] c);
        return c > HALF;
    endfunction

    always_comb begin
        mismatch = osc_sync[SYNC-1] ^ {N{ref_sync[SYNC-1]}};
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = cnt[i] + CNT_W'(mismatch[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            res.spins_valid <= 1'b0;
            res.spins       <= '0;
            res.counts      <= '0;
            flush_cnt       <= '0;
            win_cnt         <= '0;
            ref_sync        <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            for (int j = 0; j < SYNC; j++) osc_sync[j] <= '0;
        end else begin
            // synchronizer stage boundary: free-running in every state
            osc_sync[0] <= osc_in;
            for (int j = 1; j < SYNC; j++) osc_sync[j] <= osc_sync[j-1];
            ref_sync <= {ref_sync[SYNC-2:0], ref_in};

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FLUSH;
                        busy      <= 1'b1;
                        flush_cnt <= '0;
                        win_cnt   <= '0;
                        for (int i = 0; i < N; i++) cnt[i] <= '0;
                    end
                end
                S_FLUSH: begin
                    // Flush spans the acceptance cycle plus SYNC cycles, so the first
                    // counted sample was taken after the start edge.
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (flush_cnt == FL_LAST) begin
                        state <= S_MEAS;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                S_MEAS: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
                        win_cnt <= win_cnt + 1'b1;
                        if (win_cnt == LAST) begin
                            state           <= S_DONE;
                            res.spins_valid <= 1'b1;
                            for (int i = 0; i < N; i++) begin
                                res.counts[i*CNT_W +: CNT_W] <= cnt_next[i];
                                res.spins[i]                 <= resolve_spin(cnt_next[i]);
                            end
                        end
                    end
                end
                default: begin
                    if (abort || res.spins_ready) begin
                        state           <= S_IDLE;
                        busy            <= 1'b0;
                        res.spins_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
